// File: rtl/paquete_red_pkg.sv
// Types and constants shared by the receive arbiter, the processor and the link blocks.
// The round-robin helper lives here so every block walks the links in the same order.
package paquete_red_pkg;

   localparam int ANCHO_DATO  = 8;
   localparam int ANCHO_ID    = 4;
   localparam int NUM_CANALES = 3;

   typedef enum logic [1:0] {
      CANAL_A = 2'd0,
      CANAL_B = 2'd1,
      CANAL_C = 2'd2
   } canal_t;

   typedef enum logic {
      ESPERA   = 1'b0,
      PRESENTA = 1'b1
   } estado_arbitro_t;

   function automatic canal_t canal_siguiente(input canal_t canal);
      canal_t resultado;
      case (canal)
         CANAL_A: resultado = CANAL_B;
         CANAL_B: resultado = CANAL_C;
         default: resultado = CANAL_A;
      endcase
      return resultado;
   endfunction

   // Walks ultimo+1, ultimo+2, ultimo+3 (mod 3); returns ultimo when nothing is pending.
   function automatic canal_t elegir_round_robin(input canal_t ultimo,
                                                 input logic [NUM_CANALES-1:0] pendientes);
      canal_t candidato;
      canal_t elegido;
      logic   encontrado;
      candidato  = ultimo;
      elegido    = ultimo;
      encontrado = 1'b0;
      for (int k = 0; k < NUM_CANALES; k++) begin
         candidato = canal_siguiente(candidato);
         if (!encontrado && pendientes[candidato]) begin
            elegido    = candidato;
            encontrado = 1'b1;
         end
      end
      return elegido;
   endfunction

endpackage

// File: rtl/registro_canal.sv
// Holding register for one receive link: captures a byte on its pulse and keeps it pending
// until the arbiter releases it; a pulse that finds the register occupied is dropped.
module registro_canal #(
   parameter int ANCHO_DATO = 8
) (
   input  logic                  reloj,
   input  logic                  reinicio,
   input  logic                  carga_i,
   input  logic [ANCHO_DATO-1:0] dato_i,
   input  logic                  liberar_i,
   output logic                  pendiente_o,
   output logic [ANCHO_DATO-1:0] dato_o,
   output logic                  perdida_o
);

   logic                  pendiente_q, pendiente_d;
   logic [ANCHO_DATO-1:0] dato_q, dato_d;
   logic                  admite_carga;

   // A release in the same cycle frees the slot, so the new byte takes its place.
   assign admite_carga = carga_i & (~pendiente_q | liberar_i);

   always_comb begin
      pendiente_d = pendiente_q;
      dato_d      = dato_q;
      if (admite_carga) begin
         pendiente_d = 1'b1;
         dato_d      = dato_i;
      end else if (liberar_i) begin
         pendiente_d = 1'b0;
      end
   end

   always_ff @(posedge reloj) begin
      if (reinicio) begin
         pendiente_q <= 1'b0;
         dato_q      <= '0;
      end else begin
         pendiente_q <= pendiente_d;
         dato_q      <= dato_d;
      end
   end

   assign pendiente_o = pendiente_q;
   assign dato_o      = dato_q;
   assign perdida_o   = carga_i & pendiente_q & ~liberar_i;

endmodule

// File: rtl/arbitro_recepcion.sv
// Merges three receive links into one processor-facing byte stream with round-robin grants
// and a saturating count of bytes lost to overflow.
//
// state    | meaning
// ESPERA   | nothing presented; grant next pending link at the following edge
// PRESENTA | datoSalida/canalOrigen held with datoValido=1 until datoAceptado
module arbitro_recepcion #(
   parameter int ANCHO_DATO     = paquete_red_pkg::ANCHO_DATO,
   parameter int ANCHO_CONTADOR = 4
) (
   input  logic                      reloj,
   input  logic                      reinicio,
   input  logic                      recepcionFinalizadaA,
   input  logic                      recepcionFinalizadaB,
   input  logic                      recepcionFinalizadaC,
   input  logic [ANCHO_DATO-1:0]     datoA,
   input  logic [ANCHO_DATO-1:0]     datoB,
   input  logic [ANCHO_DATO-1:0]     datoC,
   output logic                      datoValido,
   output logic [ANCHO_DATO-1:0]     datoSalida,
   output logic [1:0]                canalOrigen,
   input  logic                      datoAceptado,
   output logic [ANCHO_CONTADOR-1:0] cantidadPerdidos
);

   import paquete_red_pkg::*;

   localparam int ANCHO_SUMA = ANCHO_CONTADOR + 2;
   localparam logic [ANCHO_CONTADOR-1:0] CONTADOR_MAX = {ANCHO_CONTADOR{1'b1}};

   estado_arbitro_t           estado_q;
   canal_t                    ultimo_q;
   canal_t                    canalOrigen_q;
   canal_t                    concesion;
   logic                      datoValido_q;
   logic [ANCHO_DATO-1:0]     datoSalida_q;
   logic [ANCHO_CONTADOR-1:0] perdidos_q, perdidos_d;

   logic [NUM_CANALES-1:0]    pendiente;
   logic [NUM_CANALES-1:0]    liberar;
   logic [NUM_CANALES-1:0]    perdida;
   logic [ANCHO_DATO-1:0]     retenidoA, retenidoB, retenidoC;
   logic [ANCHO_DATO-1:0]     dato_concedido;
   logic                      aceptacion;
   logic [ANCHO_SUMA-1:0]     suma_perdidas;
   logic [ANCHO_SUMA-1:0]     total_perdidos;

   assign aceptacion = (estado_q == PRESENTA) & datoAceptado;
   assign liberar[0] = aceptacion & (canalOrigen_q == CANAL_A);
   assign liberar[1] = aceptacion & (canalOrigen_q == CANAL_B);
   assign liberar[2] = aceptacion & (canalOrigen_q == CANAL_C);

   registro_canal #(.ANCHO_DATO(ANCHO_DATO)) u_registro_a (
      .reloj       (reloj),
      .reinicio    (reinicio),
      .carga_i     (recepcionFinalizadaA),
      .dato_i      (datoA),
      .liberar_i   (liberar[0]),
      .pendiente_o (pendiente[0]),
      .dato_o      (retenidoA),
      .perdida_o   (perdida[0])
   );

   registro_canal #(.ANCHO_DATO(ANCHO_DATO)) u_registro_b (
      .reloj       (reloj),
      .reinicio    (reinicio),
      .carga_i     (recepcionFinalizadaB),
      .dato_i      (datoB),
      .liberar_i   (liberar[1]),
      .pendiente_o (pendiente[1]),
      .dato_o      (retenidoB),
      .perdida_o   (perdida[1])
   );

   registro_canal #(.ANCHO_DATO(ANCHO_DATO)) u_registro_c (
      .reloj       (reloj),
      .reinicio    (reinicio),
      .carga_i     (recepcionFinalizadaC),
      .dato_i      (datoC),
      .liberar_i   (liberar[2]),
      .pendiente_o (pendiente[2]),
      .dato_o      (retenidoC),
      .perdida_o   (perdida[2])
   );

   assign concesion = elegir_round_robin(ultimo_q, pendiente);

   always_comb begin
      case (concesion)
         CANAL_A: dato_concedido = retenidoA;
         CANAL_B: dato_concedido = retenidoB;
         default: dato_concedido = retenidoC;
      endcase
   end

   // Up to three drops can land in one cycle; sum them wide, then clamp.
   always_comb begin
      suma_perdidas  = ANCHO_SUMA'(perdida[0]) + ANCHO_SUMA'(perdida[1])
                     + ANCHO_SUMA'(perdida[2]);
      total_perdidos = ANCHO_SUMA'(perdidos_q) + suma_perdidas;
      if (total_perdidos > ANCHO_SUMA'(CONTADOR_MAX)) begin
         perdidos_d = CONTADOR_MAX;
      end else begin
         perdidos_d = total_perdidos[ANCHO_CONTADOR-1:0];
      end
   end

   always_ff @(posedge reloj) begin
      if (reinicio) begin
         estado_q      <= ESPERA;
         ultimo_q      <= CANAL_C;
         canalOrigen_q <= CANAL_A;
         datoValido_q  <= 1'b0;
         datoSalida_q  <= '0;
      end else begin
         case (estado_q)
            ESPERA: begin
               if (|pendiente) begin
                  estado_q      <= PRESENTA;
                  datoValido_q  <= 1'b1;
                  datoSalida_q  <= dato_concedido;
                  canalOrigen_q <= concesion;
               end
            end
            PRESENTA: begin
               if (datoAceptado) begin
                  estado_q     <= ESPERA;
                  datoValido_q <= 1'b0;
                  ultimo_q     <= canalOrigen_q;
               end
            end
            default: begin
               estado_q     <= ESPERA;
               datoValido_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge reloj) begin
      if (reinicio) begin
         perdidos_q <= '0;
      end else begin
         perdidos_q <= perdidos_d;
      end
   end

   assign datoValido       = datoValido_q;
   assign datoSalida       = datoSalida_q;
   assign canalOrigen      = canalOrigen_q;
   assign cantidadPerdidos = perdidos_q;

endmodule

// File: tb/tb_arbitro_recepcion.sv
// Bench for arbitro_recepcion: directed scenarios with fixed expectations plus a random run,
// every cycle compared against a slot-level reference model of the arbiter.
module tb_arbitro_recepcion;

   logic       reloj = 1'b0;
   logic       reinicio = 1'b1;
   logic       pA = 1'b0, pB = 1'b0, pC = 1'b0;
   logic [7:0] dA = '0, dB = '0, dC = '0;
   logic       acepta = 1'b0;
   logic       datoValido;
   logic [7:0] datoSalida;
   logic [1:0] canalOrigen;
   logic [3:0] cantidadPerdidos;

   int n_aserciones = 0;
   int n_fallos     = 0;

   int m_pend[3];
   int m_byte[3];
   int m_valid, m_out, m_src, m_ultimo, m_cnt;

   int prev_valid = 0;
   int concesiones[$];

   always #5 reloj = ~reloj;

   arbitro_recepcion #(.ANCHO_DATO(8), .ANCHO_CONTADOR(4)) dut (
      .reloj                (reloj),
      .reinicio             (reinicio),
      .recepcionFinalizadaA (pA),
      .recepcionFinalizadaB (pB),
      .recepcionFinalizadaC (pC),
      .datoA                (dA),
      .datoB                (dB),
      .datoC                (dC),
      .datoValido           (datoValido),
      .datoSalida           (datoSalida),
      .canalOrigen          (canalOrigen),
      .datoAceptado         (acepta),
      .cantidadPerdidos     (cantidadPerdidos)
   );

   task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_aserciones++;
      if (obs !== esp) begin
         n_fallos++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
      end
   endtask

   // Reference: three slots, one presented byte, round-robin from the last accepted link.
   task automatic modelo(input logic [2:0] pul, input int d0, input int d1, input int d2,
                         input logic ac, input logic rs);
      int dat[3];
      int liberado, elegido, cand, caidas;
      dat = '{d0, d1, d2};
      if (rs) begin
         m_pend   = '{0, 0, 0};
         m_byte   = '{0, 0, 0};
         m_valid  = 0;
         m_out    = 0;
         m_src    = 0;
         m_ultimo = 2;
         m_cnt    = 0;
         return;
      end
      liberado = (m_valid != 0 && ac) ? m_src : -1;
      if (m_valid == 0) begin
         elegido = -1;
         for (int k = 1; k <= 3; k++) begin
            cand = (m_ultimo + k) % 3;
            if (elegido < 0 && m_pend[cand] != 0) elegido = cand;
         end
         if (elegido >= 0) begin
            m_valid = 1;
            m_src   = elegido;
            m_out   = m_byte[elegido];
         end
      end else if (ac) begin
         m_valid  = 0;
         m_ultimo = m_src;
      end
      caidas = 0;
      for (int x = 0; x < 3; x++) begin
         if (pul[x]) begin
            if (m_pend[x] != 0 && liberado != x) begin
               caidas++;
            end else begin
               m_byte[x] = dat[x];
               m_pend[x] = 1;
            end
         end else if (liberado == x) begin
            m_pend[x] = 0;
         end
      end
      m_cnt = (m_cnt + caidas > 15) ? 15 : m_cnt + caidas;
   endtask

   task automatic paso(input logic [2:0] pul, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic ac, input logic rs);
      reinicio = rs;
      pA = pul[0]; pB = pul[1]; pC = pul[2];
      dA = a; dB = b; dC = c;
      acepta = ac;
      @(posedge reloj);
      modelo(pul, int'(a), int'(b), int'(c), ac, rs);
      #1;
      comprobar("modelo_valido", 32'(datoValido), 32'(m_valid));
      comprobar("modelo_salida", 32'(datoSalida), 32'(m_out));
      comprobar("modelo_origen", 32'(canalOrigen), 32'(m_src));
      comprobar("modelo_perdidos", 32'(cantidadPerdidos), 32'(m_cnt));
      if (datoValido === 1'b1 && prev_valid == 0) concesiones.push_back(int'(canalOrigen));
      prev_valid = (datoValido === 1'b1) ? 1 : 0;
   endtask

   task automatic reiniciar();
      paso(3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      concesiones.delete();
   endtask

   task automatic ocioso(input logic ac);
      paso(3'b000, 8'h00, 8'h00, 8'h00, ac, 1'b0);
   endtask

   initial begin
      logic [2:0] pul;
      logic [7:0] ra, rb, rc;

      // Single byte: latency, hold while not accepted, drop of datoValido after accept
      reiniciar();
      comprobar("reset_valido", 32'(datoValido), 32'h0);
      comprobar("reset_salida", 32'(datoSalida), 32'h0);
      comprobar("reset_origen", 32'(canalOrigen), 32'h0);
      comprobar("reset_perdidos", 32'(cantidadPerdidos), 32'h0);
      paso(3'b001, 8'h35, 8'h00, 8'h00, 1'b0, 1'b0);
      comprobar("unico_latencia", 32'(datoValido), 32'h0);
      ocioso(1'b0);
      comprobar("unico_valido", 32'(datoValido), 32'h1);
      comprobar("unico_salida", 32'(datoSalida), 32'h35);
      comprobar("unico_origen", 32'(canalOrigen), 32'h0);
      repeat (5) begin
         ocioso(1'b0);
         comprobar("unico_estable", 32'({datoValido, datoSalida}), 32'h135);
      end
      ocioso(1'b1);
      comprobar("unico_aceptado", 32'(datoValido), 32'h0);

      // Three simultaneous pulses, acceptance tied high
      reiniciar();
      paso(3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0);
      repeat (7) ocioso(1'b1);
      comprobar("simul_cuenta", 32'(concesiones.size()), 32'd3);
      if (concesiones.size() == 3) begin
         comprobar("simul_orden0", 32'(concesiones[0]), 32'd0);
         comprobar("simul_orden1", 32'(concesiones[1]), 32'd1);
         comprobar("simul_orden2", 32'(concesiones[2]), 32'd2);
      end
      comprobar("simul_perdidos", 32'(cantidadPerdidos), 32'h0);

      // Fairness: B and C refilled on release, A added while C is presented
      reiniciar();
      paso(3'b110, 8'h00, 8'hB0, 8'hC0, 1'b1, 1'b0);
      for (int i = 0; i < 40 && concesiones.size() < 5; i++) begin
         pul = 3'b000;
         if (m_valid != 0) pul[m_src] = 1'b1;
         if (concesiones.size() == 4 && m_valid != 0 && m_src == 2) pul[0] = 1'b1;
         paso(pul, 8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i), 1'b1, 1'b0);
      end
      comprobar("rr_cuenta", 32'(concesiones.size()), 32'd5);
      if (concesiones.size() == 5) begin
         comprobar("rr_0", 32'(concesiones[0]), 32'd1);
         comprobar("rr_1", 32'(concesiones[1]), 32'd2);
         comprobar("rr_2", 32'(concesiones[2]), 32'd1);
         comprobar("rr_3", 32'(concesiones[3]), 32'd2);
         comprobar("rr_a", 32'(concesiones[4]), 32'd0);
      end

      // Overflow on B and saturation
      reiniciar();
      paso(3'b010, 8'h00, 8'h41, 8'h00, 1'b0, 1'b0);
      paso(3'b010, 8'h00, 8'h42, 8'h00, 1'b0, 1'b0);
      paso(3'b010, 8'h00, 8'h43, 8'h00, 1'b0, 1'b0);
      ocioso(1'b0);
      comprobar("desb_salida", 32'(datoSalida), 32'h41);
      comprobar("desb_origen", 32'(canalOrigen), 32'h1);
      comprobar("desb_perdidos", 32'(cantidadPerdidos), 32'd2);
      repeat (20) paso(3'b010, 8'h00, 8'($urandom), 8'h00, 1'b0, 1'b0);
      comprobar("desb_saturado", 32'(cantidadPerdidos), 32'd15);
      comprobar("desb_retiene", 32'(datoSalida), 32'h41);

      // Pulse on B in the same cycle B is released
      reiniciar();
      paso(3'b010, 8'h00, 8'h44, 8'h00, 1'b0, 1'b0);
      ocioso(1'b0);
      comprobar("colision_prev", 32'(datoSalida), 32'h44);
      paso(3'b010, 8'h00, 8'h55, 8'h00, 1'b1, 1'b0);
      comprobar("colision_sin_perdida", 32'(cantidadPerdidos), 32'h0);
      comprobar("colision_hueco", 32'(datoValido), 32'h0);
      ocioso(1'b0);
      comprobar("colision_valido", 32'(datoValido), 32'h1);
      comprobar("colision_salida", 32'(datoSalida), 32'h55);
      comprobar("colision_origen", 32'(canalOrigen), 32'h1);

      // Reset while presenting, with A and C pending and pulses/accept at the reset edge
      reiniciar();
      paso(3'b101, 8'hA1, 8'h00, 8'hC3, 1'b0, 1'b0);
      ocioso(1'b0);
      comprobar("rst_previo", 32'({datoValido, canalOrigen}), 32'h4);
      paso(3'b111, 8'hAA, 8'hBB, 8'hCC, 1'b1, 1'b1);
      comprobar("rst_valido", 32'(datoValido), 32'h0);
      comprobar("rst_salida", 32'(datoSalida), 32'h0);
      comprobar("rst_origen", 32'(canalOrigen), 32'h0);
      repeat (3) begin
         ocioso(1'b1);
         comprobar("rst_sin_rancio", 32'(datoValido), 32'h0);
      end
      paso(3'b001, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0);
      ocioso(1'b0);
      comprobar("rst_nuevo_origen", 32'(canalOrigen), 32'h0);
      comprobar("rst_nuevo_salida", 32'(datoSalida), 32'h5A);

      // Random traffic against the model
      reiniciar();
      for (int i = 0; i < 3000; i++) begin
         pul[0] = ($urandom_range(0, 99) < 40);
         pul[1] = ($urandom_range(0, 99) < 40);
         pul[2] = ($urandom_range(0, 99) < 40);
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 8'($urandom);
         paso(pul, ra, rb, rc, 1'($urandom_range(0, 1)), ($urandom_range(0, 149) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_aserciones, n_fallos);
      $finish;
   end

endmodule

// File: doc/arbitro_recepcion.md
ARBITRO_RECEPCION -- requirements
Module: arbitro_recepcion

Interface
REQ-001 Parameter ANCHO_DATO, default 8, is the byte width per link; the upper 4 bits are the destination ID and the lower 4 bits are the payload.
REQ-002 Parameter ANCHO_CONTADOR, default 4, is the width of the dropped-byte counter.
REQ-003 reloj  input  1  is the single clock; all state changes on its rising edge.
REQ-004 reinicio  input  1  is a synchronous, active-high reset.
REQ-005 recepcionFinalizadaA/B/C  input  1 each  is a one-cycle pulse: link X finished receiving a byte.
REQ-006 datoA/B/C  input  ANCHO_DATO each  is the link-X received byte, valid while its pulse is high.
REQ-007 datoValido  output  1  means the presented byte is held for the processor.
REQ-008 datoSalida  output  ANCHO_DATO  is the presented byte.
REQ-009 canalOrigen  output  2  is the source link of the presented byte: 0=A, 1=B, 2=C.
REQ-010 datoAceptado  input  1  is the processor's acknowledgement; it is ignored while datoValido=0.
REQ-011 cantidadPerdidos  output  ANCHO_CONTADOR  counts bytes dropped due to overflow.

Function
REQ-012 The block SHALL provide one holding register per link (byte plus pendiente flag); each pulse loads its register at that edge.
REQ-013 Pulses on A, B and C in the same cycle SHALL all be captured, with no loss.
REQ-014 A pulse on link X while pendienteX=1 and X is not being released that cycle SHALL be dropped.
  - The old byte is kept.
  - cantidadPerdidos increments, saturating at 2^ANCHO_CONTADOR-1.
  - Two or three simultaneous drops in one cycle SHALL add 2 or 3, still saturating.
REQ-015 A pulse on X in the same cycle X is released (datoValido & datoAceptado with canalOrigen=X) SHALL load the new byte with no drop.
REQ-016 The FSM SHALL have two states: ESPERA and PRESENTA.
  - ESPERA -> PRESENTA when any pendiente=1.
  - PRESENTA -> ESPERA on datoAceptado=1.
  - All other cases hold the current state.
REQ-017 On ESPERA->PRESENTA, the grant SHALL be round-robin from pointer ultimo.
  - Search order: ultimo+1, ultimo+2, ultimo+3, all mod 3.
  - datoSalida and canalOrigen register the granted link's byte and index.
REQ-018 In PRESENTA, datoValido=1, and datoSalida and canalOrigen SHALL stay stable until acceptance.
REQ-019 On acceptance the granted pendiente SHALL clear, ultimo becomes canalOrigen, and datoValido falls at the next edge.
  - datoValido is low for at least one cycle between grants.
REQ-020 Latency: a pulse sampled at edge E with the FSM in ESPERA SHALL give datoValido=1 after edge E+1.
REQ-021 The next grant after acceptance SHALL occur at the edge following the ESPERA cycle.
  - Sustained throughput is one byte per 2 cycles when datoAceptado is tied high.
REQ-022 The block SHALL only sequence bytes and SHALL NOT inspect the destination ID.

Reset
REQ-023 While reinicio=1 at an edge:
  - All pendiente flags clear.
  - FSM = ESPERA.
  - ultimo = 2 (C), so A has first priority.
  - datoValido=0, datoSalida=0, canalOrigen=0, cantidadPerdidos=0.
REQ-024 Reset SHALL take priority over simultaneous pulses and acceptance; a byte presented at reset is discarded.

Structure
REQ-025 Package paquete_red_pkg SHALL hold the following, all shared with the processor and link blocks:
  - canal_t (CANAL_A=0, CANAL_B=1, CANAL_C=2)
  - estado_arbitro_t (ESPERA, PRESENTA)
  - ANCHO_DATO
  - ANCHO_ID=4
REQ-026 Sub-module registro_canal SHALL implement one holding register: load, release, pendiente, and a drop pulse.
  - It is instantiated three times.
  - The arbiter FSM, round-robin and counter stay in arbitro_recepcion.

Verification
REQ-027 Single byte: reset, then A pulse with datoA=8'h35.
  - After 2 edges: datoValido=1, datoSalida=8'h35, canalOrigen=0.
  - Hold datoAceptado=0 for 5 cycles -> outputs stable.
  - Accept -> datoValido=0 next cycle.
REQ-028 Simultaneous pulses: A=8'h11, B=8'h22, C=8'h33 in one cycle, datoAceptado tied 1.
  - Grants come in order A, B, C, one every 2 cycles.
  - cantidadPerdidos=0.
REQ-029 Round-robin fairness: keep B and C continuously refilled after each release.
  - Grants alternate B, C, B, C.
  - Then add A after a C grant -> A is granted next.
REQ-030 Overflow: hold datoAceptado=0 and send three pulses on B (8'h41, 8'h42, 8'h43).
  - datoSalida=8'h41.
  - cantidadPerdidos=2.
  - Then send 20 more B pulses -> cantidadPerdidos saturates at 15.
REQ-031 Release collision: pulse B=8'h55 in the same cycle B=8'h44 is accepted.
  - No drop.
  - B=8'h55 is later presented.
REQ-032 Reset mid-operation: assert reinicio while datoValido=1 and A and C are pending.
  - All outputs return to 0.
  - No stale byte is presented afterward.
  - The next A pulse is granted first.
